// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_pkg
//  Description : Shared types and defaults for the Mandelbrot pixel scheduler.
//  Revision    : 1.0
// ============================================================================
package mandel_pkg;

    localparam int XW = 10;
    localparam int YW = 9;

    localparam int DEF_X_SIZE      = 640;
    localparam int DEF_Y_SIZE      = 480;
    localparam int DEF_NUM_ENGINES = 4;
    localparam int DEF_ITER_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mandel_pixel_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_pixel_scheduler_if
//  Description : Engine job/result lanes and pixel output stream of the scheduler.
//  Revision    : 1.0
// ============================================================================
interface mandel_pixel_scheduler_if #(
    parameter int NUM_ENGINES = mandel_pkg::DEF_NUM_ENGINES,
    parameter int ITER_W      = mandel_pkg::DEF_ITER_W
);
    logic [NUM_ENGINES-1:0]        job_valid;
    logic [NUM_ENGINES-1:0]        job_ready;
    logic [mandel_pkg::XW-1:0]     job_x;
    logic [mandel_pkg::YW-1:0]     job_y;
    logic [NUM_ENGINES-1:0]        res_valid;
    logic [NUM_ENGINES*ITER_W-1:0] res_iter;
    logic [NUM_ENGINES-1:0]        res_ack;
    logic                          pix_valid;
    logic                          pix_ready;
    logic [ITER_W-1:0]             pix_iter;
    logic                          pix_sof;
    logic                          pix_eol;

    modport master (
        output job_valid, job_x, job_y, res_ack,
        output pix_valid, pix_iter, pix_sof, pix_eol,
        input  job_ready, res_valid, res_iter, pix_ready
    );

    modport slave (
        input  job_valid, job_x, job_y, res_ack,
        input  pix_valid, pix_iter, pix_sof, pix_eol,
        output job_ready, res_valid, res_iter, pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : x/y raster walker; x wraps at X_SIZE-1 and then y advances.
//  Revision    : 1.0
// ============================================================================
module raster_counter
    import mandel_pkg::*;
#(
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int Y_SIZE = DEF_Y_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_step,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last_x,
    output logic          o_last_y,
    output logic          o_wrap
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_last_x = (r_x == XW'(X_SIZE - 1));
    assign o_last_y = (r_y == YW'(Y_SIZE - 1));
    // Stepping off the final pixel of the frame.
    assign o_wrap   = i_step & o_last_x & o_last_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (o_last_x) begin
                r_x <= '0;
                r_y <= o_last_y ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mandel_pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_pixel_scheduler
//  Description : Issues raster jobs round-robin to the iteration engines and
//                retires their results in raster order onto the pixel stream.
//  Revision    : 1.0
// ============================================================================
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int X_SIZE      = DEF_X_SIZE,
    parameter int Y_SIZE      = DEF_Y_SIZE,
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int ITER_W      = DEF_ITER_W
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    mandel_pixel_scheduler_if.master bus
);

    localparam int PW = $clog2(NUM_ENGINES);

    state_t                  r_state;
    logic [PW-1:0]           r_issue_ptr;
    logic [PW-1:0]           r_retire_ptr;
    logic [NUM_ENGINES-1:0]  r_busy_eng;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_pix_valid;
    logic [ITER_W-1:0]       r_pix_iter;
    logic                    r_pix_sof;
    logic                    r_pix_eol;
    logic                    r_pix_last;

    logic                    w_start_ok;
    logic                    w_issue_ok;
    logic                    w_issue_fire;
    logic                    w_retire;
    logic                    w_frame_end;
    logic [NUM_ENGINES-1:0]  w_busy_next;
    logic [ITER_W-1:0]       w_res_slice;

    logic [XW-1:0]           w_iss_x;
    logic [YW-1:0]           w_iss_y;
    logic                    w_iss_wrap;
    logic                    w_iss_last_x_unused;
    logic                    w_iss_last_y_unused;
    logic [XW-1:0]           w_ret_x;
    logic [YW-1:0]           w_ret_y;
    logic                    w_ret_last_x;
    logic                    w_ret_last_y;
    logic                    w_ret_wrap_unused;

    assign w_start_ok   = (r_state == ST_IDLE) & start;
    assign w_issue_ok   = (r_state == ST_RUN) & ~r_busy_eng[r_issue_ptr];
    assign w_issue_fire = w_issue_ok & bus.job_ready[r_issue_ptr];
    // Retire only the engine holding the oldest outstanding pixel, and only
    // when the output register is free or being emptied this cycle.
    assign w_retire     = (r_state != ST_IDLE) & r_busy_eng[r_retire_ptr]
                        & bus.res_valid[r_retire_ptr]
                        & (~r_pix_valid | bus.pix_ready);
    assign w_frame_end  = (r_state == ST_DRAIN) & r_pix_valid & bus.pix_ready & r_pix_last;
    assign w_res_slice  = bus.res_iter[int'(r_retire_ptr) * ITER_W +: ITER_W];

    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_issue_cnt (
        .clk      (out_stream_aclk),
        .rst      (periph_reset),
        .i_clear  (w_start_ok),
        .i_step   (w_issue_fire),
        .o_x      (w_iss_x),
        .o_y      (w_iss_y),
        .o_last_x (w_iss_last_x_unused),
        .o_last_y (w_iss_last_y_unused),
        .o_wrap   (w_iss_wrap)
    );

    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_retire_cnt (
        .clk      (out_stream_aclk),
        .rst      (periph_reset),
        .i_clear  (w_start_ok),
        .i_step   (w_retire),
        .o_x      (w_ret_x),
        .o_y      (w_ret_y),
        .o_last_x (w_ret_last_x),
        .o_last_y (w_ret_last_y),
        .o_wrap   (w_ret_wrap_unused)
    );

    always_comb begin
        bus.job_valid = '0;
        bus.res_ack   = '0;
        w_busy_next   = r_busy_eng;
        if (w_issue_ok) begin
            bus.job_valid[r_issue_ptr] = 1'b1;
        end
        if (w_retire) begin
            bus.res_ack[r_retire_ptr] = 1'b1;
            w_busy_next[r_retire_ptr] = 1'b0;
        end
        if (w_issue_fire) begin
            w_busy_next[r_issue_ptr] = 1'b1;
        end
    end

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            r_state      <= ST_IDLE;
            r_issue_ptr  <= '0;
            r_retire_ptr <= '0;
            r_busy_eng   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_iter   <= '0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_last   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_busy_eng   <= w_busy_next;
            if (w_issue_fire) begin
                r_issue_ptr <= r_issue_ptr + PW'(1);
            end
            if (w_retire) begin
                r_retire_ptr <= r_retire_ptr + PW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b1;
                        r_issue_ptr  <= '0;
                        r_retire_ptr <= '0;
                        r_busy_eng   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_iss_wrap) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_frame_end) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_retire) begin
                r_pix_valid <= 1'b1;
                r_pix_iter  <= w_res_slice;
                r_pix_sof   <= (w_ret_x == '0) && (w_ret_y == '0);
                r_pix_eol   <= w_ret_last_x;
                r_pix_last  <= w_ret_last_x & w_ret_last_y;
            end else if (bus.pix_ready) begin
                r_pix_valid <= 1'b0;
            end
        end
    end

    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign bus.job_x     = w_iss_x;
    assign bus.job_y     = w_iss_y;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_iter  = r_pix_iter;
    assign bus.pix_sof   = r_pix_sof;
    assign bus.pix_eol   = r_pix_eol;

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mandel_pixel_scheduler
//  Description : Self-checking bench with latency-modelled engines on a 4x2 raster.
//  Revision    : 1.0
// ============================================================================
module tb_mandel_pixel_scheduler;

    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int NE   = 4;
    localparam int IW   = 8;
    localparam int NPIX = XS * YS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    mandel_pixel_scheduler_if #(.NUM_ENGINES(NE), .ITER_W(IW)) bus ();

    mandel_pixel_scheduler #(
        .X_SIZE(XS), .Y_SIZE(YS), .NUM_ENGINES(NE), .ITER_W(IW)
    ) dut (
        .out_stream_aclk (clk),
        .periph_reset    (rst),
        .start           (start),
        .busy            (busy),
        .frame_done      (frame_done),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned seed;
    bit          eng_busy [NE];
    int          eng_cnt  [NE];
    logic [7:0]  eng_iter [NE];
    int          lat_cfg  [NE];
    bit          lat_rand, rdy_rand, m_stall, m_spam, m_rst;
    int          stall_cnt, jr_hold;
    bit          start_req, start_acc_prev;
    bit          in_frame;
    int          iss_idx, pix_idx, fd_count;
    bit          exp_fd;
    bit          prev_stall;
    logic [7:0]  prev_iter;
    logic        prev_sof, prev_eol;
    logic [NE-1:0] prev_jv;
    logic [9:0]  prev_jx;
    logic [8:0]  prev_jy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-coordinate iteration count the engines "compute".
    function automatic logic [7:0] ref_iter(input int x, input int y);
        return 8'((x * 37) ^ (y * 101) ^ int'(seed));
    endfunction

    task automatic step();
        bit b0 [NE];
        @(negedge clk);
        start     = start_req;
        start_req = 1'b0;
        if (stall_cnt > 0) begin
            bus.pix_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.pix_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        for (int i = 0; i < NE; i++) begin
            if (i == 2 && jr_hold > 0) bus.job_ready[i] = 1'b0;
            else bus.job_ready[i] = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (eng_busy[i]) begin
                bus.res_valid[i]         = (eng_cnt[i] == 0);
                bus.res_iter[i*IW +: IW] = eng_iter[i];
            end else begin
                bus.res_valid[i]         = 1'($urandom_range(0, 1));
                bus.res_iter[i*IW +: IW] = 8'($urandom);
            end
        end
        if (jr_hold > 0) jr_hold--;
        #1;

        if (start_acc_prev) check_eq("busy_after_start", busy, 1);
        start_acc_prev = 1'b0;
        if (start && !in_frame) begin
            in_frame = 1'b1;
            iss_idx  = 0;
            pix_idx  = 0;
            start_acc_prev = 1'b1;
        end

        check_eq("frame_done", frame_done, exp_fd);
        exp_fd = 1'b0;
        if (frame_done) begin
            fd_count++;
            check_eq("busy_at_done", busy, 0);
        end

        if (prev_stall) begin
            check_eq("hold_valid", bus.pix_valid, 1);
            check_eq("hold_iter", bus.pix_iter, prev_iter);
            check_eq("hold_sof", bus.pix_sof, prev_sof);
            check_eq("hold_eol", bus.pix_eol, prev_eol);
        end
        if (bus.pix_valid && !bus.pix_ready) check_eq("ack_while_stalled", bus.res_ack, 0);
        if (prev_jv != '0) begin
            check_eq("job_hold_valid", bus.job_valid, prev_jv);
            check_eq("job_hold_x", bus.job_x, prev_jx);
            check_eq("job_hold_y", bus.job_y, prev_jy);
        end
        if (bus.job_valid != '0) check_eq("job_onehot", $countones(bus.job_valid), 1);

        for (int i = 0; i < NE; i++) b0[i] = eng_busy[i];
        for (int i = 0; i < NE; i++) begin
            if (bus.res_ack[i]) begin
                check_eq("ack_has_result", b0[i] && eng_cnt[i] == 0, 1);
                eng_busy[i] = 1'b0;
            end
        end
        for (int i = 0; i < NE; i++) begin
            if (bus.job_valid[i] && bus.job_ready[i]) begin
                check_eq("issue_in_frame", in_frame && iss_idx < NPIX, 1);
                check_eq("issue_engine", i, iss_idx % NE);
                check_eq("job_x", bus.job_x, iss_idx % XS);
                check_eq("job_y", bus.job_y, iss_idx / XS);
                check_eq("issue_to_busy", b0[i], 0);
                eng_busy[i] = 1'b1;
                eng_cnt[i]  = lat_rand ? $urandom_range(1, 12) : lat_cfg[i] + 1;
                eng_iter[i] = ref_iter(int'(bus.job_x), int'(bus.job_y));
                iss_idx++;
            end
        end

        if (bus.pix_valid && bus.pix_ready) begin
            check_eq("pix_in_frame", in_frame && pix_idx < NPIX, 1);
            check_eq("pix_iter", bus.pix_iter, ref_iter(pix_idx % XS, pix_idx / XS));
            check_eq("pix_sof", bus.pix_sof, pix_idx == 0);
            check_eq("pix_eol", bus.pix_eol, (pix_idx % XS) == XS - 1);
            check_eq("busy_in_frame", busy, 1);
            pix_idx++;
            if (pix_idx == NPIX) begin
                exp_fd   = 1'b1;
                in_frame = 1'b0;
            end
        end

        for (int i = 0; i < NE; i++) begin
            if (eng_busy[i] && eng_cnt[i] > 0) eng_cnt[i]--;
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_iter  = bus.pix_iter;
        prev_sof   = bus.pix_sof;
        prev_eol   = bus.pix_eol;
        prev_jv    = ((bus.job_valid & ~bus.job_ready) != '0) ? bus.job_valid : '0;
        prev_jx    = bus.job_x;
        prev_jy    = bus.job_y;
    endtask

    task automatic apply_reset();
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_job_valid", bus.job_valid, 0);
        check_eq("rst_job_xy", {bus.job_x, bus.job_y}, 0);
        check_eq("rst_res_ack", bus.res_ack, 0);
        check_eq("rst_pix_valid", bus.pix_valid, 0);
        check_eq("rst_pix_data", {bus.pix_iter, bus.pix_sof, bus.pix_eol}, 0);
        for (int i = 0; i < NE; i++) begin
            eng_busy[i] = 1'b0;
            eng_cnt[i]  = 0;
        end
        in_frame = 1'b0; exp_fd = 1'b0; prev_stall = 1'b0; prev_jv = '0;
        start_req = 1'b0; start_acc_prev = 1'b0; stall_cnt = 0; jr_hold = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame();
        int n;
        bit s1, s2, st;
        n = 0; s1 = 1'b0; s2 = 1'b0; st = 1'b0;
        seed      = $urandom;
        fd_count  = 0;
        start_req = 1'b1;
        while (fd_count == 0 && n < 2000) begin
            step();
            n++;
            if (m_stall && !st && pix_idx == 3) begin
                stall_cnt = 10;
                st = 1'b1;
            end
            if (m_spam && !s1 && in_frame && iss_idx == 3) begin
                start_req = 1'b1;
                s1 = 1'b1;
            end
            if (m_spam && !s2 && in_frame && iss_idx == NPIX && pix_idx < NPIX - 1) begin
                start_req = 1'b1;
                s2 = 1'b1;
            end
            if (m_rst && pix_idx == 3) begin
                apply_reset();
                return;
            end
        end
        repeat (6) step();
        check_eq("frame_done_count", fd_count, 1);
        check_eq("pixel_count", pix_idx, NPIX);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat_cfg[0] = l0; lat_cfg[1] = l1; lat_cfg[2] = l2; lat_cfg[3] = l3;
    endtask

    initial begin
        bus.job_ready = '0;
        bus.res_valid = '0;
        bus.res_iter  = '0;
        bus.pix_ready = 1'b0;
        lat_rand = 0; rdy_rand = 0; m_stall = 0; m_spam = 0; m_rst = 0;
        apply_reset();

        set_lat(3, 3, 3, 3);
        run_frame();

        set_lat(9, 1, 5, 2);
        run_frame();

        set_lat(3, 3, 3, 3);
        m_stall = 1;
        run_frame();
        m_stall = 0;

        set_lat(10, 10, 10, 10);
        m_spam = 1;
        run_frame();
        m_spam = 0;

        lat_rand = 1;
        m_rst = 1;
        run_frame();
        m_rst = 0;
        run_frame();
        lat_rand = 0;

        set_lat(3, 3, 3, 3);
        jr_hold = 22;
        run_frame();

        lat_rand = 1;
        rdy_rand = 1;
        repeat (4) run_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
